// File: rtl/local_history_predictor_if.sv
// Fetch-side lookup and resolve-side update bundle for the local-history predictor.
// The predictor sits on the slave modport; the fetch/resolve logic drives the master side.
interface local_history_predictor_if #(
    parameter int FETCH_WIDTH  = 2,
    parameter int UPDATE_WIDTH = 2,
    parameter int HIST_BITS    = 6,
    parameter int ADDR_WIDTH   = 32
);
    // Every valid here is a qualifier only and has no ready: fetchValid/updValid are
    // sampled on the edge that ends their cycle, predValid is held while stall is high.
    logic                               fetchValid;
    logic [ADDR_WIDTH-1:0]              fetchPC;
    logic                               stall;
    logic                               flush;
    logic [FETCH_WIDTH-1:0]             slotIsCondBr;
    logic                               predValid;
    logic [FETCH_WIDTH-1:0]             predTaken;
    logic [FETCH_WIDTH*HIST_BITS-1:0]   predHistory;
    logic                               initBusy;
    logic [UPDATE_WIDTH-1:0]            updValid;
    logic [UPDATE_WIDTH*ADDR_WIDTH-1:0] updPC;
    logic [UPDATE_WIDTH*HIST_BITS-1:0]  updHistory;
    logic [UPDATE_WIDTH-1:0]            updTaken;
    logic [UPDATE_WIDTH-1:0]            updMispred;
    logic [UPDATE_WIDTH-1:0]            updIsCondBr;
    logic [UPDATE_WIDTH-1:0]            updDropped;

    modport master (
        output fetchValid, fetchPC, stall, flush, slotIsCondBr,
        output updValid, updPC, updHistory, updTaken, updMispred, updIsCondBr,
        input  predValid, predTaken, predHistory, initBusy, updDropped
    );

    modport slave (
        input  fetchValid, fetchPC, stall, flush, slotIsCondBr,
        input  updValid, updPC, updHistory, updTaken, updMispred, updIsCondBr,
        output predValid, predTaken, predHistory, initBusy, updDropped
    );
endinterface

// File: rtl/local_history_predictor.sv
// Two-level local-history direction predictor: per-line history table (BHT) feeding a
// pattern table (PHT) of saturating counters, with a 2-stage lookup pipeline and init sweep.
module local_history_predictor #(
    parameter int FETCH_WIDTH  = 2,
    parameter int UPDATE_WIDTH = 2,
    parameter int BHT_BITS     = 8,
    parameter int HIST_BITS    = 6,
    parameter int SET_BITS     = 2,
    parameter int CTR_BITS     = 2,
    parameter int PC_LSB       = 2,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rstN,
    local_history_predictor_if.slave bus,
    output logic                     dbg_state
);
    localparam int PHT_BITS    = SET_BITS + HIST_BITS;
    localparam int INIT_BITS   = (PHT_BITS > BHT_BITS) ? PHT_BITS : BHT_BITS;
    localparam int NUM_WR      = FETCH_WIDTH + UPDATE_WIDTH;
    localparam int BHT_ENTRIES = 1 << BHT_BITS;
    localparam int PHT_ENTRIES = 1 << PHT_BITS;

    typedef logic [BHT_BITS-1:0]  bidx_t;
    typedef logic [HIST_BITS-1:0] hist_t;
    typedef logic [PHT_BITS-1:0]  pidx_t;
    typedef logic [CTR_BITS-1:0]  ctr_t;
    typedef enum logic { ST_INIT = 1'b0, ST_RUN = 1'b1 } state_e;

    localparam ctr_t CTR_WEAK = ctr_t'(1 << (CTR_BITS - 1));

    // The set bits are the low SET_BITS of the line index, so the PHT index is the low
    // PHT_BITS of {line, hist}; SET_BITS == 0 collapses to pure history (PAg).
    function automatic pidx_t pht_index(input bidx_t line, input hist_t hist);
        return PHT_BITS'({line, hist});
    endfunction

    state_e                  state_q, state_d;
    logic [INIT_BITS-1:0]    idx_q, idx_d;
    logic                    run;

    hist_t                   bht_q [BHT_ENTRIES];
    ctr_t                    pht_q [PHT_ENTRIES];

    logic                    wr_en   [NUM_WR];
    bidx_t                   wr_idx  [NUM_WR];
    hist_t                   wr_data [NUM_WR];

    logic                    upd_en    [UPDATE_WIDTH];
    pidx_t                   upd_pidx  [UPDATE_WIDTH];
    logic                    pht_we    [UPDATE_WIDTH];
    ctr_t                    pht_wdata [UPDATE_WIDTH];
    logic [UPDATE_WIDTH-1:0] drop;

    logic                    s1_valid_q, s1_valid_d;
    bidx_t                   s1_line_q, s1_line_d;
    hist_t                   s1_hist_q [FETCH_WIDTH];
    hist_t                   s1_hist_d [FETCH_WIDTH];
    hist_t                   rd_hist   [FETCH_WIDTH];

    logic [FETCH_WIDTH-1:0]  s2_taken;
    logic                    pred_valid_q, pred_valid_d;
    logic [FETCH_WIDTH-1:0]  pred_taken_q, pred_taken_d;
    hist_t                   pred_hist_q [FETCH_WIDTH];
    hist_t                   pred_hist_d [FETCH_WIDTH];
    logic [UPDATE_WIDTH-1:0] upd_dropped_q, upd_dropped_d;

    logic                    unused_pc_bits;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_INIT: begin
                idx_d = idx_q + 1'b1;
                if (&idx_q) state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    assign run = (state_q == ST_RUN);

    // BHT write ports in ascending priority: speculative slots, then repairs by port,
    // so a repair overrides a speculative write and the youngest repair wins.
    always_comb begin
        logic  blocked;
        bidx_t line;
        hist_t uhist;
        blocked  = 1'b0;
        line     = '0;
        uhist    = '0;
        s2_taken = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_en[k]   = 1'b0;
            wr_idx[k]  = '0;
            wr_data[k] = '0;
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            line = s1_line_q + bidx_t'(i);
            if (bus.slotIsCondBr[i] && !blocked) begin
                s2_taken[i] = s1_valid_q & pht_q[pht_index(line, s1_hist_q[i])][CTR_BITS-1];
                wr_en[i]    = s1_valid_q & ~bus.stall & ~bus.flush;
                wr_idx[i]   = line;
                wr_data[i]  = {s1_hist_q[i][HIST_BITS-2:0], s2_taken[i]};
                blocked     = s2_taken[i];
            end
        end
        for (int u = 0; u < UPDATE_WIDTH; u++) begin
            line        = bus.updPC[u*ADDR_WIDTH+PC_LSB +: BHT_BITS];
            uhist       = bus.updHistory[u*HIST_BITS +: HIST_BITS];
            upd_en[u]   = run & bus.updValid[u] & bus.updIsCondBr[u];
            upd_pidx[u] = pht_index(line, uhist);
            wr_en[FETCH_WIDTH+u]   = upd_en[u] & bus.updMispred[u];
            wr_idx[FETCH_WIDTH+u]  = line;
            wr_data[FETCH_WIDTH+u] = {uhist[HIST_BITS-2:0], bus.updTaken[u]};
        end
    end

    always_comb begin
        ctr_t ctr;
        ctr = '0;
        for (int u = 0; u < UPDATE_WIDTH; u++) begin
            drop[u] = 1'b0;
            for (int v = 0; v < u; v++) begin
                if (upd_en[v] && upd_pidx[v] == upd_pidx[u]) drop[u] = upd_en[u];
            end
            pht_we[u] = upd_en[u] & ~drop[u];
            ctr       = pht_q[upd_pidx[u]];
            if (bus.updTaken[u]) pht_wdata[u] = (&ctr) ? ctr : ctr + 1'b1;
            else                 pht_wdata[u] = (|ctr) ? ctr - 1'b1 : ctr;
        end
    end

    // S1 reads see this cycle's BHT writes, applied in the same priority order as the array.
    always_comb begin
        bidx_t ridx;
        ridx = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            ridx       = bus.fetchPC[PC_LSB +: BHT_BITS] + bidx_t'(i);
            rd_hist[i] = bht_q[ridx];
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && wr_idx[k] == ridx) rd_hist[i] = wr_data[k];
            end
        end
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_line_d     = s1_line_q;
        s1_hist_d     = s1_hist_q;
        pred_valid_d  = pred_valid_q;
        pred_taken_d  = pred_taken_q;
        pred_hist_d   = pred_hist_q;
        upd_dropped_d = drop;
        if (bus.flush) begin
            s1_valid_d   = 1'b0;
            pred_valid_d = 1'b0;
        end else if (!bus.stall) begin
            s1_valid_d   = bus.fetchValid & run;
            s1_line_d    = bus.fetchPC[PC_LSB +: BHT_BITS];
            s1_hist_d    = rd_hist;
            pred_valid_d = s1_valid_q;
            pred_taken_d = s2_taken;
            pred_hist_d  = s1_hist_q;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= ST_INIT;
            idx_q         <= '0;
            s1_valid_q    <= 1'b0;
            s1_line_q     <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= '0;
            upd_dropped_q <= '0;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                s1_hist_q[i]   <= '0;
                pred_hist_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            s1_valid_q    <= s1_valid_d;
            s1_line_q     <= s1_line_d;
            s1_hist_q     <= s1_hist_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_hist_q   <= pred_hist_d;
            upd_dropped_q <= upd_dropped_d;
        end
    end

    // Tables are not reset; the init sweep clears them one entry per cycle.
    always_ff @(posedge clk) begin
        if (!run && int'(idx_q) < BHT_ENTRIES) bht_q[idx_q[BHT_BITS-1:0]] <= '0;
        if (!run && int'(idx_q) < PHT_ENTRIES) pht_q[idx_q[PHT_BITS-1:0]] <= CTR_WEAK;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k]) bht_q[wr_idx[k]] <= wr_data[k];
        end
        for (int u = 0; u < UPDATE_WIDTH; u++) begin
            if (pht_we[u]) pht_q[upd_pidx[u]] <= pht_wdata[u];
        end
    end

    always_comb begin
        bus.predHistory = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            bus.predHistory[i*HIST_BITS +: HIST_BITS] = pred_hist_q[i];
        end
    end

    assign bus.predValid   = pred_valid_q;
    assign bus.predTaken   = pred_taken_q;
    assign bus.initBusy    = ~run;
    assign bus.updDropped  = upd_dropped_q;
    assign dbg_state       = state_q;
    assign unused_pc_bits  = ^{bus.fetchPC, bus.updPC};
endmodule
